// File: rtl/sram_port_arbiter.sv
// Two-port arbiter and access sequencer for the shared data SRAM.
// Fetch (I, read-only) and load/store (D) requests are granted combinationally
// with round-robin on conflicts; each grant becomes one registered SRAM access
// cycle followed by a registered one-cycle response pulse.
module sram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_d_q;       // 1: most recent grant went to D
  logic [3:0]          we_q;           // byte enables of the D access in flight
  logic [3:0]          sram_w_en_q;
  logic [ADDR_W-1:0]   sram_address_q;
  logic [DATA_W-1:0]   sram_write_data_q;
  logic                i_rvalid_q, d_rvalid_q, d_err_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  // Only load, byte, half and word enable patterns are accepted.
  function automatic logic we_legal(input logic [3:0] we);
    return (we == 4'b0000) || (we == 4'b0001) || (we == 4'b0011) || (we == 4'b1111);
  endfunction

  // Combinational grant: D wins a conflict unless it was granted last.
  always_comb begin
    i_gnt = !rst && i_req && (!d_req || last_d_q);
    d_gnt = !rst && d_req && (!i_req || !last_d_q);
  end

  // Next access state follows whichever port was granted this cycle.
  always_comb begin
    state_d = IDLE;
    if (d_gnt)      state_d = ACC_D;
    else if (i_gnt) state_d = ACC_I;
  end

  // Access sequencer: latch granted request onto the SRAM bus, then respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      last_d_q          <= 1'b0;
      we_q              <= 4'b0000;
      sram_w_en_q       <= 4'b0000;
      sram_address_q    <= '0;
      sram_write_data_q <= '0;
      i_rvalid_q        <= 1'b0;
      d_rvalid_q        <= 1'b0;
      d_err_q           <= 1'b0;
      i_rdata_q         <= '0;
      d_rdata_q         <= '0;
    end else begin
      state_q     <= state_d;
      sram_w_en_q <= 4'b0000;
      if (d_gnt) begin
        last_d_q          <= 1'b1;
        we_q              <= d_we;
        sram_address_q    <= d_addr;
        sram_write_data_q <= d_wdata;
        sram_w_en_q       <= we_legal(d_we) ? d_we : 4'b0000;
      end else if (i_gnt) begin
        last_d_q       <= 1'b0;
        sram_address_q <= i_addr;
      end

      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      case (state_q)
        ACC_I: begin
          i_rvalid_q <= 1'b1;
          i_rdata_q  <= sram_read_data;
        end
        ACC_D: begin
          d_rvalid_q <= 1'b1;
          d_err_q    <= !we_legal(we_q);
          // Stores leave the previous load data in place.
          if ((we_q == 4'b0000) || !we_legal(we_q)) d_rdata_q <= sram_read_data;
        end
        default: ;
      endcase
    end
  end

  assign sram_w_en       = sram_w_en_q;
  assign sram_address    = sram_address_q;
  assign sram_write_data = sram_write_data_q;
  assign i_rvalid        = i_rvalid_q;
  assign i_rdata         = i_rdata_q;
  assign d_rvalid        = d_rvalid_q;
  assign d_rdata         = d_rdata_q;
  assign d_err           = d_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: byte-array SRAM model plus a transaction-level
// reference (grant rule, in-order execution on a shadow memory).
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [15:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data), .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // SRAM model: combinational read, byte-enabled write, addresses wrap at 0xFFFF.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) ^ (i >> 8));
  endfunction

  assign sram_read_data = {mem[sram_address + 16'd3], mem[sram_address + 16'd2],
                           mem[sram_address + 16'd1], mem[sram_address]};

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_byte(i);
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (sram_w_en[b]) mem[sram_address + 16'(b)] <= sram_write_data[8*b +: 8];
    end
  end

  // Reference model state
  typedef struct {
    bit          is_d;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          due;
  } txn_t;

  txn_t        q[$];
  int          cyc;
  bit          last_m;       // 1: last grant was D
  bit          gi_m, gd_m;
  logic [15:0] addr_m;
  logic [31:0] irdata_m, drdata_m;
  int          checks = 0;
  int          errors = 0;

  function automatic bit legal(input logic [3:0] we);
    return (we == 4'h0) || (we == 4'h1) || (we == 4'h3) || (we == 4'hF);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit ir, input logic [15:0] ia, input bit dr,
                     input logic [3:0] dwe, input logic [15:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
  endtask

  // One clock cycle: called 1ns after a rising edge, checks mid-cycle, returns 1ns after the next edge.
  task automatic step();
    txn_t        t;
    bit          ivld_e, dvld_e, derr_e, eg_i, eg_d;
    logic [3:0]  wen_e;
    #4;
    ivld_e = 0; dvld_e = 0; derr_e = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      t = q.pop_front();
      if (!t.is_d) begin
        ivld_e   = 1;
        irdata_m = ref_rd(t.addr);
      end else begin
        dvld_e = 1;
        if (legal(t.we) && t.we != 4'h0) begin
          for (int b = 0; b < 4; b++)
            if (t.we[b]) ref_mem[t.addr + 16'(b)] = t.wdata[8*b +: 8];
        end else begin
          drdata_m = ref_rd(t.addr);
          derr_e   = !legal(t.we);
        end
      end
    end
    chk("i_rvalid", {31'h0, i_rvalid}, {31'h0, ivld_e});
    chk("d_rvalid", {31'h0, d_rvalid}, {31'h0, dvld_e});
    chk("d_err", {31'h0, d_err}, {31'h0, derr_e});
    chk("i_rdata", i_rdata, irdata_m);
    chk("d_rdata", d_rdata, drdata_m);

    wen_e = 4'h0;
    foreach (q[k]) begin
      if (q[k].due == cyc + 1) begin
        addr_m = q[k].addr;
        if (q[k].is_d) begin
          wen_e = legal(q[k].we) ? q[k].we : 4'h0;
          chk("sram_wdata", sram_write_data, q[k].wdata);
        end
      end
    end
    chk("sram_w_en", {28'h0, sram_w_en}, {28'h0, wen_e});
    chk("sram_addr", {16'h0, sram_address}, {16'h0, addr_m});

    eg_d = d_req && (!i_req || !last_m);
    eg_i = i_req && (!d_req || last_m);
    chk("i_gnt", {31'h0, i_gnt}, {31'h0, eg_i});
    chk("d_gnt", {31'h0, d_gnt}, {31'h0, eg_d});
    if (eg_d) begin
      q.push_back('{is_d: 1'b1, addr: d_addr, we: d_we, wdata: d_wdata, due: cyc + 2});
      last_m = 1'b1;
    end else if (eg_i) begin
      q.push_back('{is_d: 1'b0, addr: i_addr, we: 4'h0, wdata: 32'h0, due: cyc + 2});
      last_m = 1'b0;
    end
    gi_m = eg_i; gd_m = eg_d;
    @(posedge clk); cyc++; #1;
  endtask

  // Asserts reset mid-cycle, checks cleared outputs, releases 1ns after the next edge.
  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    #2;
    chk("rst_w_en", {28'h0, sram_w_en}, 32'h0);
    chk("rst_addr", {16'h0, sram_address}, 32'h0);
    chk("rst_wdata", sram_write_data, 32'h0);
    chk("rst_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    chk("rst_err", {31'h0, d_err}, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_gnt", {30'h0, i_gnt, d_gnt}, 32'h0);
    q.delete();
    last_m = 1'b0; gi_m = 1'b0; gd_m = 1'b0;
    addr_m = 16'h0; irdata_m = 32'h0; drdata_m = 32'h0;
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    @(posedge clk); cyc++; #1;
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 16'hFFFC + 16'($urandom_range(0, 3));
    return 16'($urandom_range(0, 1023));
  endfunction

  function automatic logic [3:0] rnd_we();
    case ($urandom_range(0, 9))
      0, 1, 2: return 4'h0;
      3, 4:    return 4'h1;
      5, 6:    return 4'h3;
      7, 8:    return 4'hF;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  int diffs;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    ref_mem[16'h0010] = 8'h11; ref_mem[16'h0011] = 8'h22;
    ref_mem[16'h0012] = 8'h33; ref_mem[16'h0013] = 8'h44;
    cyc = 0;
    rst = 1'b0;
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    #1;
    do_reset();

    // Lone fetch
    drv(1, 16'h0010, 0, 4'h0, 16'h0, 32'h0); step();
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);    step();
    chk("fetch_data", i_rdata, 32'h44332211);
    step();

    // Store then load, then byte store and reload
    drv(0, 16'h0, 1, 4'hF, 16'h0100, 32'hDEADBEEF); step();
    drv(0, 16'h0, 1, 4'h0, 16'h0100, 32'h0);        step();
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);           step(); step();
    chk("lw_after_sw", d_rdata, 32'hDEADBEEF);
    drv(0, 16'h0, 1, 4'h1, 16'h0101, 32'h0000005A); step();
    drv(0, 16'h0, 1, 4'h0, 16'h0100, 32'h0);        step();
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);           step(); step();
    chk("lw_after_sb", d_rdata, 32'hDEAD5AEF);

    // Contention from reset: D first, then strict alternation
    do_reset();
    drv(1, 16'h0040, 1, 4'h0, 16'h0080, 32'h0);
    for (int k = 0; k < 6; k++) step();
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    step(); step(); step();

    // Back-to-back fetches
    for (int k = 0; k < 4; k++) begin
      drv(1, 16'(4 * k), 0, 4'h0, 16'h0, 32'h0); step();
    end
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    step(); step(); step();

    // Illegal byte enable
    drv(0, 16'h0, 1, 4'b0101, 16'h0200, 32'h12345678); step();
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    chk("illegal_w_en", {28'h0, sram_w_en}, 32'h0);
    step();
    chk("illegal_err", {31'h0, d_err}, 32'h1);
    chk("illegal_mem", {mem[16'h0203], mem[16'h0202], mem[16'h0201], mem[16'h0200]}, ref_rd(16'h0200));
    step();

    // Reset during the access cycle of a store
    drv(0, 16'h0, 1, 4'hF, 16'h0300, 32'hCAFEF00D); step();
    chk("pre_rst_w_en", {28'h0, sram_w_en}, 32'hF);
    do_reset();
    step();
    chk("rst_store_dropped", {mem[16'h0303], mem[16'h0302], mem[16'h0301], mem[16'h0300]}, ref_rd(16'h0300));

    // Randomized traffic obeying the hold-until-granted rule
    for (int n = 0; n < 400; n++) begin
      if (!i_req || gi_m) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = rnd_addr();
      end
      if (!d_req || gd_m) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_addr  = rnd_addr();
        d_we    = rnd_we();
        d_wdata = $urandom;
      end
      step();
    end
    drv(0, 16'h0, 0, 4'h0, 16'h0, 32'h0);
    step(); step(); step();

    diffs = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_final", 32'(diffs), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
